adau_scan: RTL and testbench

- Parametrised multi-channel analog acquisition sequencer; the next generation of the current single-stream acquisition unit.
- On each `sec` pulse it emits one frame:
  - a sync word first;
  - then, for each of N_CH table-defined mux settings: select the channel, settle, convert, shift the result in serially, park the mux on ground, and present the sample on a valid/ready stream.
- Drives the analog mux (ENA/ADDR) and an AD7983-style serial ADC directly.
- Sits between the channel-table RAM and the UART/packet stream logic.

---
 rtl/adau_scan.sv | 250 +++++++++++++++++++++++++
 tb/tb_adau_scan.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adau_scan.sv
// adau_scan: sequencer for one frame per `sec`. Each frame is a sync word followed by one sample per
// channel, taken from a table-driven analog mux through a serial ADC. Build option: ADAU_OVERSAMPLE_EN.
`timescale 1ns/1ps

module adau_scan #(
    parameter int          N_CH        = 64,
    parameter int          DATA_W      = 16,
    parameter int          SETTLE_CLKS = 170,
    parameter int          CONV_CLKS   = 8,
    parameter int          PARK_CLKS   = 72,
    parameter logic [15:0] SYNC_WORD   = 16'hFF7F,
    parameter logic [3:0]  PARK_ENA    = 4'h1,
    parameter logic [3:0]  PARK_ADDR   = 4'hF,
    parameter int          OSR_LOG2    = 2
) (
    input  logic              clk_5Mhz,
    input  logic              reset,
    input  logic              sec,
    output logic [7:0]        tbl_addr,
    input  logic [7:0]        tbl_data,
    output logic [3:0]        ENA,
    output logic [3:0]        ADDR,
    output logic              CNV,
    output logic              SCK,
    input  logic              SDO,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sync,
    output logic [7:0]        out_chan,
    output logic              frame_done,
    output logic              overrun
);

`ifdef ADAU_OVERSAMPLE_EN
    localparam int OSR = OSR_LOG2;
`else
    // Single pass per channel: the oversampling ratio collapses to 1.
    localparam int OSR = 0 * OSR_LOG2;
`endif
    localparam int SHIFT_CLKS = 2 * DATA_W;
    localparam int MAX_A      = (SETTLE_CLKS > CONV_CLKS) ? SETTLE_CLKS : CONV_CLKS;
    localparam int MAX_B      = (SHIFT_CLKS > PARK_CLKS) ? SHIFT_CLKS : PARK_CLKS;
    localparam int CNT_MAX    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int PASS_W     = (OSR > 0) ? OSR : 1;

    localparam logic [CNT_W-1:0]  SETTLE_END = CNT_W'(SETTLE_CLKS - 1);
    localparam logic [CNT_W-1:0]  CONV_END   = CNT_W'(CONV_CLKS - 1);
    localparam logic [CNT_W-1:0]  SHIFT_END  = CNT_W'(SHIFT_CLKS - 1);
    localparam logic [CNT_W-1:0]  PARK_END   = CNT_W'(PARK_CLKS - 1);
    localparam logic [PASS_W-1:0] LAST_PASS  = PASS_W'((1 << OSR) - 1);
    localparam logic [7:0]        LAST_IDX   = 8'(N_CH - 1);
    localparam logic [DATA_W-1:0] SYNC_W     = DATA_W'(SYNC_WORD);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_TBL_ADDR,
        ST_TBL_LATCH,
        ST_SETTLE,
        ST_CONV,
        ST_SHIFT,
        ST_GAP,
        ST_EMIT,
        ST_PARK
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic [7:0]          idx_q, idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [7:0]          chan_q, chan_d;
    logic [3:0]          ena_q, ena_d;
    logic [3:0]          addr_q, addr_d;
    logic                overrun_q, overrun_d;
    logic [DATA_W-1:0]   sample_out;

`ifdef ADAU_OVERSAMPLE_EN
    localparam int ACC_W = DATA_W + OSR;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] acc_sum;

    assign acc_sum    = acc_q + ACC_W'(shift_q);
    assign sample_out = acc_sum[ACC_W-1:OSR];
`else
    assign sample_out = shift_q;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pass_d     = pass_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        data_d     = data_q;
        chan_d     = chan_q;
        ena_d      = ena_q;
        addr_d     = addr_q;
        overrun_d  = 1'b0;
        frame_done = 1'b0;
`ifdef ADAU_OVERSAMPLE_EN
        acc_d      = acc_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (sec) begin
                    state_d = ST_SYNC;
                    idx_d   = 8'd0;
                    data_d  = SYNC_W;
                    chan_d  = 8'd0;
                end
            end
            ST_SYNC: begin
                if (out_ready) state_d = ST_TBL_ADDR;
            end
            ST_TBL_ADDR: begin
                state_d = ST_TBL_LATCH;
            end
            ST_TBL_LATCH: begin
                ena_d   = tbl_data[3:0];
                addr_d  = tbl_data[7:4];
                cnt_d   = '0;
                pass_d  = '0;
`ifdef ADAU_OVERSAMPLE_EN
                acc_d   = '0;
`endif
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SETTLE_END) begin
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CONV_END) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Even counts are SCK-high; the bit is taken on the edge that ends them.
                if (!cnt_q[0]) shift_d = {shift_q[DATA_W-2:0], SDO};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SHIFT_END) begin
                    cnt_d = '0;
                    if (pass_q == LAST_PASS) begin
                        ena_d   = PARK_ENA;
                        addr_d  = PARK_ADDR;
                        data_d  = sample_out;
                        chan_d  = idx_q;
                        state_d = ST_EMIT;
                    end else begin
                        pass_d  = pass_q + PASS_W'(1);
`ifdef ADAU_OVERSAMPLE_EN
                        acc_d   = acc_sum;
`endif
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                state_d = ST_CONV;
            end
            ST_EMIT: begin
                if (out_ready) begin
                    cnt_d   = '0;
                    state_d = ST_PARK;
                end
            end
            ST_PARK: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == PARK_END) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        frame_done = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = ST_TBL_ADDR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A strobe mid-frame abandons the frame and restarts it with a fresh sync word.
        if (sec && state_q != ST_IDLE) begin
            state_d   = ST_SYNC;
            idx_d     = 8'd0;
            cnt_d     = '0;
            pass_d    = '0;
            ena_d     = PARK_ENA;
            addr_d    = PARK_ADDR;
            data_d    = SYNC_W;
            chan_d    = 8'd0;
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_5Mhz or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pass_q    <= '0;
            idx_q     <= 8'd0;
            shift_q   <= '0;
            data_q    <= '0;
            chan_q    <= 8'd0;
            ena_q     <= PARK_ENA;
            addr_q    <= PARK_ADDR;
            overrun_q <= 1'b0;
`ifdef ADAU_OVERSAMPLE_EN
            acc_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pass_q    <= pass_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            chan_q    <= chan_d;
            ena_q     <= ena_d;
            addr_q    <= addr_d;
            overrun_q <= overrun_d;
`ifdef ADAU_OVERSAMPLE_EN
            acc_q     <= acc_d;
`endif
        end
    end

    assign tbl_addr  = idx_q;
    assign ENA       = ena_q;
    assign ADDR      = addr_q;
    assign CNV       = (state_q == ST_CONV);
    assign SCK       = (state_q == ST_SHIFT) && !cnt_q[0];
    assign out_valid = (state_q == ST_SYNC) || (state_q == ST_EMIT);
    assign out_sync  = (state_q == ST_SYNC);
    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_adau_scan.sv
// Bench for adau_scan: a frame-level word scoreboard plus timing/mux observers, driven by directed frames.
`timescale 1ns/1ps

module tb_adau_scan;
    localparam int N_CH        = 4;
    localparam int DATA_W      = 16;
    localparam int SETTLE_CLKS = 170;
    localparam int CONV_CLKS   = 8;
    localparam int PARK_CLKS   = 72;
    localparam int OSR_LOG2    = 2;
`ifdef ADAU_OVERSAMPLE_EN
    localparam int          N_PASS = 1 << OSR_LOG2;
    localparam logic [15:0] BASE1  = 16'd100;
    localparam logic [15:0] LIT1   = 16'd101;
    localparam logic [15:0] BASE2  = 16'h0200;
    localparam logic [15:0] LIT2   = 16'h0201;
`else
    localparam int          N_PASS = 1;
    localparam logic [15:0] BASE1  = 16'hA5C3;
    localparam logic [15:0] LIT1   = 16'hA5C3;
    localparam logic [15:0] BASE2  = 16'h3C5A;
    localparam logic [15:0] LIT2   = 16'h3C5A;
`endif
    localparam int CH_PERIOD = 2 + SETTLE_CLKS + N_PASS * (CONV_CLKS + 2 * DATA_W)
                             + (N_PASS - 1) + 1 + PARK_CLKS;

    logic        clk_5Mhz = 1'b0;
    logic        reset = 1'b1;
    logic        sec = 1'b0;
    logic [7:0]  tbl_addr;
    logic [7:0]  tbl_data;
    logic [3:0]  ENA, ADDR;
    logic        CNV, SCK, SDO;
    logic        out_valid, out_sync, frame_done, overrun;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [7:0]  out_chan;

    adau_scan #(.N_CH(N_CH), .DATA_W(DATA_W), .OSR_LOG2(OSR_LOG2)) dut (
        .clk_5Mhz(clk_5Mhz), .reset(reset), .sec(sec),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .ENA(ENA), .ADDR(ADDR), .CNV(CNV), .SCK(SCK), .SDO(SDO),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sync(out_sync), .out_chan(out_chan),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #100 clk_5Mhz = ~clk_5Mhz;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Channel table with one cycle of read latency
    logic [7:0] tbl_mem [0:3];
    always @(posedge clk_5Mhz) tbl_data <= tbl_mem[tbl_addr[1:0]];

    // ADC: conversion result is base + pass number within the current channel visit
    logic [15:0] adc_base = 16'h0;
    logic [15:0] adc_sr = 16'h0;
    logic [15:0] adc_pass = 16'h0;
    logic        cnv_d1 = 1'b0;
    assign SDO = adc_sr[15];
    always @(posedge clk_5Mhz) begin
        if (CNV) adc_sr <= adc_base + adc_pass;
        else if (SCK) adc_sr <= {adc_sr[14:0], 1'b0};
        if (ENA == 4'h1 && ADDR == 4'hF) adc_pass <= 16'h0;
        else if (cnv_d1 && !CNV) adc_pass <= adc_pass + 16'h1;
        cnv_d1 <= CNV;
    end

    function automatic logic [15:0] exp_sample(input logic [15:0] base);
        int sum = 0;
        for (int k = 0; k < N_PASS; k++) sum += int'(base) + k;
        return 16'(sum / N_PASS);
    endfunction

    typedef struct {
        logic [15:0] data;
        logic        sync;
        logic [7:0]  chan;
    } word_t;
    word_t exp_q[$];

    int   cycle = 0;
    always @(posedge clk_5Mhz) cycle <= cycle + 1;

    logic        busy = 1'b0, ovr_exp = 1'b0;
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_sync = 1'b0;
    logic [15:0] prev_data = 16'h0;
    logic [7:0]  prev_chan = 8'h0;
    logic        cnv_prev = 1'b0, sck_prev = 1'b0, stalled = 1'b0;
    int          done_due = -1, cnv_run = 0, sck_pulses = 0, cnv_count = 0;
    int          prev_acc_chan = -1, last_acc_cycle = 0, done_pulses = 0;

    always @(negedge clk_5Mhz) begin
        if (reset) begin
            exp_q.delete();
            busy = 1'b0; ovr_exp = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
            cnv_prev = 1'b0; sck_prev = 1'b0; stalled = 1'b0;
            done_due = -1; cnv_run = 0; sck_pulses = 0; cnv_count = 0; prev_acc_chan = -1;
        end else begin
            logic exp_done;
            check("overrun", overrun, ovr_exp);
            exp_done = (done_due == cycle);
            check("frame_done", frame_done, exp_done);
            if (frame_done) done_pulses++;
            if (exp_done) done_due = -1;

            if (prev_valid && !prev_ready) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
                check("hold_sync", out_sync, prev_sync);
                check("hold_chan", out_chan, prev_chan);
            end

            if (CNV) cnv_run++;
            else if (cnv_run > 0) begin
                check("cnv_width", cnv_run, CONV_CLKS);
                cnv_run = 0;
                sck_pulses = 0;
            end
            if (CNV && !cnv_prev) begin
                cnv_count++;
                if (exp_q.size() > 0 && !exp_q[0].sync) begin
                    check("mux_ena", ENA, tbl_mem[exp_q[0].chan[1:0]][3:0]);
                    check("mux_addr", ADDR, tbl_mem[exp_q[0].chan[1:0]][7:4]);
                end
            end
            if (SCK && !sck_prev) sck_pulses++;

            if (out_valid && !out_sync && !prev_valid) begin
                check("sck_pulses", sck_pulses, DATA_W);
                check("cnv_per_chan", cnv_count, N_PASS);
                check("park_ena", ENA, 4'h1);
                check("park_addr", ADDR, 4'hF);
            end

            if (!out_ready) stalled = 1'b1;
            if (out_valid && out_ready) begin
                check("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    word_t w;
                    w = exp_q.pop_front();
                    $display("word @%0d: sync=%0d chan=%0d data=%h (want sync=%0d chan=%0d data=%h)",
                             cycle, out_sync, out_chan, out_data, w.sync, w.chan, w.data);
                    check("word_data", out_data, w.data);
                    check("word_sync", out_sync, w.sync);
                    check("word_chan", out_chan, w.chan);
                    if (!w.sync) begin
                        if (prev_acc_chan >= 0 && int'(w.chan) == prev_acc_chan + 1 && !stalled)
                            check("chan_period", cycle - last_acc_cycle, CH_PERIOD);
                        prev_acc_chan  = int'(w.chan);
                        last_acc_cycle = cycle;
                        if (int'(w.chan) == N_CH - 1) done_due = cycle + PARK_CLKS;
                    end else begin
                        prev_acc_chan = -1;
                    end
                end
                stalled   = 1'b0;
                cnv_count = 0;
            end

            ovr_exp = sec && busy;
            if (sec) begin
                if (busy) begin
                    exp_q.delete();
                    done_due  = -1;
                    cnv_count = 0;
                end
                exp_q.push_back('{16'hFF7F, 1'b1, 8'd0});
                for (int c = 0; c < N_CH; c++) exp_q.push_back('{exp_sample(adc_base), 1'b0, 8'(c)});
                busy = 1'b1;
            end else if (exp_done) begin
                busy = 1'b0;
            end

            prev_valid = out_valid; prev_ready = out_ready; prev_sync = out_sync;
            prev_data  = out_data;  prev_chan  = out_chan;
            cnv_prev   = CNV;       sck_prev   = SCK;
        end
    end

    task automatic tick();
        @(posedge clk_5Mhz);
        #1;
    endtask

    task automatic pulse_sec();
        sec = 1'b1;
        tick();
        sec = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while (frame_done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check(name, n < limit, 1);
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not finish, expected finish before 5 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl_mem[0] = 8'h12; tbl_mem[1] = 8'h34; tbl_mem[2] = 8'h56; tbl_mem[3] = 8'h78;
        adc_base = BASE1;

        repeat (3) @(posedge clk_5Mhz);
        @(negedge clk_5Mhz);
        check("rst_ena", ENA, 4'h1);
        check("rst_addr", ADDR, 4'hF);
        check("rst_cnv", CNV, 0);
        check("rst_sck", SCK, 0);
        check("rst_valid", out_valid, 0);
        check("rst_sync", out_sync, 0);
        check("rst_data", out_data, 0);
        check("rst_chan", out_chan, 0);
        check("rst_tbl_addr", tbl_addr, 0);
        check("rst_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        tick();

        // Frame 1: streaming with out_ready high
        pulse_sec();
        check("f1_sync_valid", out_valid, 1);
        check("f1_sync_flag", out_sync, 1);
        check("f1_sync_data", out_data, 16'hFF7F);
        check("f1_sync_chan", out_chan, 0);
        check("f1_sync_ena", ENA, 4'h1);
        check("f1_sync_addr", ADDR, 4'hF);
        tick();
        n = 0;
        while (!(out_valid && !out_sync) && n < 2000) begin tick(); n++; end
        check("f1_first_sample_seen", n < 2000, 1);
        check("f1_first_sample", out_data, LIT1);
        check("f1_first_chan", out_chan, 0);
        wait_done("f1_done_seen", 6000);

        // Frame 2: stall the first sample for 50 cycles
        adc_base = BASE2;
        pulse_sec();
        tick();
        out_ready = 1'b0;
        n = 0;
        while (!(out_valid && !out_sync) && n < 2000) begin tick(); n++; end
        check("f2_sample_seen", n < 2000, 1);
        repeat (50) tick();
        check("f2_stall_valid", out_valid, 1);
        check("f2_stall_data", out_data, LIT2);
        check("f2_stall_chan", out_chan, 0);
        check("f2_stall_tbl_addr", tbl_addr, 0);
        out_ready = 1'b1;
        wait_done("f2_done_seen", 6000);

        // Frame 3: strobe during the shift of channel 2
        adc_base = 16'h8001;
        pulse_sec();
        n = 0;
        while (!(SCK && tbl_addr == 8'd2) && n < 6000) begin tick(); n++; end
        check("f3_shift2_seen", n < 6000, 1);
        repeat (3) tick();
        pulse_sec();
        check("f3_overrun", overrun, 1);
        check("f3_cnv_low", CNV, 0);
        check("f3_sck_low", SCK, 0);
        check("f3_ena_park", ENA, 4'h1);
        check("f3_addr_park", ADDR, 4'hF);
        check("f3_sync_valid", out_valid, 1);
        check("f3_sync_flag", out_sync, 1);
        check("f3_sync_chan", out_chan, 0);
        wait_done("f3_done_seen", 6000);

        // Reset in the middle of a conversion
        pulse_sec();
        n = 0;
        while (!CNV && n < 2000) begin tick(); n++; end
        check("f4_cnv_seen", n < 2000, 1);
        reset = 1'b1;
        #1;
        check("midrst_cnv", CNV, 0);
        check("midrst_sck", SCK, 0);
        check("midrst_ena", ENA, 4'h1);
        check("midrst_addr", ADDR, 4'hF);
        check("midrst_valid", out_valid, 0);
        check("midrst_tbl_addr", tbl_addr, 0);
        tick();
        reset = 1'b0;
        repeat (5) tick();

        check("queue_drained", exp_q.size(), 0);
        check("frame_done_pulses", done_pulses, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
